// File: rtl/uart_tx_frame_if.sv
// Host-side handshake bundle for uart_tx_frame: the word to send, the send
// request, and the busy/done status coming back from the transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_in;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_in,
    output tx_start,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_in,
    input  tx_start,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one LSB-first frame per accepted request,
// with optional parity and 1 or 2 stop bits; each bit spans OVERSAMPLE baud ticks.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              baudTick,
  uart_tx_frame_if.slave    host,
  output logic              tx
);

  localparam int   CW  = $clog2(OVERSAMPLE);
  localparam int   BW  = 4;
  localparam logic ODD = (PARITY_ODD != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE=%0d outside 4..64", OVERSAMPLE);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
    $error("uart_tx_frame: PARITY_EN=%0d must be 0 or 1", PARITY_EN);
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bit, parity_next;
  logic                 tx_r, tx_next;
  logic                 busy_r, busy_next;
  logic                 done_r, done_next;
  logic                 bit_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx_r       <= tx_next;
      busy_r     <= busy_next;
      done_r     <= done_next;
    end
  end

  assign bit_end = baudTick && (tick_cnt == CW'(OVERSAMPLE - 1));

  // bit_cnt indexes data bits in DATA and counts stop bits in STOP.
  always_comb begin
    state_next  = state;
    tick_next   = tick_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    done_next   = 1'b0;

    if (state != IDLE && baudTick) begin
      tick_next = bit_end ? '0 : tick_cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        // The done cycle is still part of the previous frame, so a request
        // seen then is deferred to the next clock.
        if (host.tx_start && !done_r) begin
          shift_next  = host.tx_in;
          parity_next = (^host.tx_in) ^ ODD;
          tick_next   = '0;
          bit_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Line level is decoded from the next state so tx is a clean register output.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign tx           = tx_r;
  assign host.tx_busy = busy_r;
  assign host.tx_done = done_r;

endmodule
